shiftreg_loader: RTL and testbench

- Upstream feeder for the parallel-load serializer shift register (MSB-first, `i_fill`/`i_fill_en`/`i_bit` inputs).
- Accepts parallel words over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Schedules one load pulse per WIDTH+GAP-cycle slot and drives the idle shift-in bit between words, so the serial output stays continuous when fed back-to-back.

---
 rtl/shiftreg_pkg.sv | 13 +
 rtl/shiftreg_loader_fifo.sv | 62 ++++++
 rtl/shiftreg_loader.sv | 128 ++++++++++++
 tb/tb_shiftreg_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the serializer word loader and its FIFO.
package shiftreg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} loader_state_t;

  localparam int FIFO_DEPTH = 2;

  // Slot counter must reach WIDTH+GAP, with GAP up to 15.
  function automatic int cnt_width(input int width);
    return $clog2(width + 16);
  endfunction

endpackage

// File: rtl/shiftreg_loader_fifo.sv
// Two-entry word buffer between the upstream handshake and the slot scheduler.
module shiftreg_loader_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_count
);
  import shiftreg_pkg::*;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;
  logic              r_ready;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count_nxt;

  assign w_push = i_valid & r_ready;
  assign w_pop  = i_ready & (r_count != 2'd0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Ready is registered so the upstream never sees a combinational path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < 2'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_data;
  end

  assign o_ready = r_ready;
  assign o_data  = r_mem[r_head];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/shiftreg_loader.sv
// Feeds a parallel-load MSB-first shift register one word per WIDTH+GAP slot.
// Optional stream-break counter enabled by defining SHIFTLOAD_UNDERRUN_CNT_EN.
module shiftreg_loader #(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_fill,
  output logic             o_fill_en,
  output logic             o_bit,
  output logic             o_busy
`ifdef SHIFTLOAD_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      o_underrun_cnt
`endif
);
  import shiftreg_pkg::*;

  localparam int               CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(WIDTH + GAP);

  loader_state_t    r_state;
  loader_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_fill;
  logic             r_fill_en;
  logic             r_bit;
  logic             w_slot_end;
  logic             w_load;
  logic             w_head_valid;
  logic [WIDTH-1:0] w_head;
  logic [1:0]       w_count;

  shiftreg_loader_fifo #(
    .DATA_W (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (w_head),
    .o_valid (w_head_valid),
    .i_ready (w_load),
    .o_count (w_count)
  );

  // The counter runs 1..WIDTH+GAP from the load edge, so a slot end lands
  // exactly WIDTH+GAP edges after the previous load.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slot_end  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = w_head_valid;
      end
      SHIFT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == SHIFT_LAST) begin
          if (GAP > 0) w_state_nxt = shiftreg_pkg::GAP;
          else         w_slot_end  = 1'b1;
        end
      end
      shiftreg_pkg::GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == SLOT_LAST) w_slot_end = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_slot_end) begin
      w_load      = w_head_valid;
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
    if (w_load) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_fill    <= '0;
      r_fill_en <= 1'b0;
      r_bit     <= IDLE_BIT;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_fill_en <= w_load;
      r_bit     <= IDLE_BIT;
      if (w_load) r_fill <= w_head;
    end
  end

  assign o_fill    = r_fill;
  assign o_fill_en = r_fill_en;
  assign o_bit     = r_bit;
  assign o_busy    = (w_count != 2'd0) | (r_state != IDLE);

`ifdef SHIFTLOAD_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  // A completed word with nothing queued behind it breaks the serial stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_underrun_cnt <= 16'd0;
    end else if (w_slot_end && !w_head_valid && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign o_underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_shiftreg_loader.sv
// Directed bench for shiftreg_loader with a downstream shift-register model (GAP=0 and GAP=3).
module tb_shiftreg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] i_data0, i_data3;
  logic       i_valid0, i_valid3;
  logic       o_ready0, o_ready3;
  logic [7:0] o_fill0, o_fill3;
  logic       o_fill_en0, o_fill_en3;
  logic       o_bit0, o_bit3;
  logic       o_busy0, o_busy3;
`ifdef SHIFTLOAD_UNDERRUN_CNT_EN
  logic [15:0] o_uc0, o_uc3;
`endif

  shiftreg_loader #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data0), .i_valid(i_valid0), .o_ready(o_ready0),
    .o_fill(o_fill0), .o_fill_en(o_fill_en0), .o_bit(o_bit0), .o_busy(o_busy0)
`ifdef SHIFTLOAD_UNDERRUN_CNT_EN
    , .o_underrun_cnt(o_uc0)
`endif
  );

  shiftreg_loader #(.WIDTH(8), .GAP(3), .IDLE_BIT(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data3), .i_valid(i_valid3), .o_ready(o_ready3),
    .o_fill(o_fill3), .o_fill_en(o_fill_en3), .o_bit(o_bit3), .o_busy(o_busy3)
`ifdef SHIFTLOAD_UNDERRUN_CNT_EN
    , .o_underrun_cnt(o_uc3)
`endif
  );

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sr0 = 8'h00;
  logic [7:0] sr3 = 8'h00;
  logic       ser0  [0:1023];
  logic       ser3  [0:1023];
  logic       busy0 [0:1023];
  int         ld0_t[$];
  logic [7:0] ld0_v[$];
  int         ld3_t[$];
  logic [7:0] ld3_v[$];

  // Downstream serializer models
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sr0 <= o_fill_en0 ? o_fill0 : {sr0[6:0], o_bit0};
    sr3 <= o_fill_en3 ? o_fill3 : {sr3[6:0], o_bit3};
  end

  always @(negedge clk) begin
    if (cyc < 1024) begin
      ser0[cyc]  <= sr0[7];
      ser3[cyc]  <= sr3[7];
      busy0[cyc] <= o_busy0;
    end
    if (o_fill_en0) begin ld0_t.push_back(cyc); ld0_v.push_back(o_fill0); end
    if (o_fill_en3) begin ld3_t.push_back(cyc); ld3_v.push_back(o_fill3); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Returns the edge number at which the word is accepted.
  task automatic push0(input logic [7:0] d, output int acc);
    int t;
    t = 0;
    i_data0  = d;
    i_valid0 = 1'b1;
    while (!o_ready0 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) chk("push0_timeout", 32'(t), 32'd0);
    acc = cyc + 1;
    @(negedge clk);
    i_valid0 = 1'b0;
    i_data0  = 8'hXX;
  endtask

  task automatic push3(input logic [7:0] d, output int acc);
    int t;
    t = 0;
    i_data3  = d;
    i_valid3 = 1'b1;
    while (!o_ready3 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) chk("push3_timeout", 32'(t), 32'd0);
    acc = cyc + 1;
    @(negedge clk);
    i_valid3 = 1'b0;
    i_data3  = 8'hXX;
  endtask

  function automatic logic [7:0] word0(input int s);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) w = {w[6:0], ser0[s + i]};
    return w;
  endfunction

  function automatic logic [7:0] word3(input int s);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) w = {w[6:0], ser3[s + i]};
    return w;
  endfunction

  logic [7:0] vals [4];

  initial begin
    int k, a0, a1, a2, a3, b0, b1, b2, g0, g1, r0, r1, lx;
    vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'hFF; vals[3] = 8'h3C;
    rst_n = 1'b0;
    i_valid0 = 1'b0; i_valid3 = 1'b0;
    i_data0 = 8'h00; i_data3 = 8'h00;
    cycles(3);
    chk("rst_ready",   32'(o_ready0),   32'd0);
    chk("rst_fill_en", 32'(o_fill_en0), 32'd0);
    chk("rst_busy",    32'(o_busy0),    32'd0);
    chk("rst_fill",    32'(o_fill0),    32'h00);
    chk("rst_bit",     32'(o_bit0),     32'd1);
    chk("rst_ready3",  32'(o_ready3),   32'd0);
    rst_n = 1'b1;
    cycles(1);
    chk("ready_after_rst", 32'(o_ready0), 32'd1);

    // Single word from idle
    ld0_t.delete(); ld0_v.delete();
    push0(8'hA5, k);
    chk("single_busy", 32'(o_busy0), 32'd1);
    cycles(12);
    chk("single_nload", 32'(ld0_t.size()), 32'd1);
    if (ld0_t.size() >= 1) begin
      chk("single_lat",  32'(ld0_t[0]), 32'(k + 1));
      chk("single_fill", 32'(ld0_v[0]), 32'hA5);
    end
    chk("single_ser",   32'(word0(k + 2)), 32'hA5);
    chk("single_idle",  32'(ser0[k + 10]), 32'd1);
    chk("busy_last",    32'(busy0[k + 8]), 32'd1);
    chk("busy_drop",    32'(busy0[k + 9]), 32'd0);

    // Back-to-back words, FIFO fills, fourth word waits
    ld0_t.delete(); ld0_v.delete();
    push0(vals[0], a0);
    push0(vals[1], a1);
    push0(vals[2], a2);
    chk("full_ready", 32'(o_ready0), 32'd0);
    push0(vals[3], a3);
    chk("held_accept", 32'(a3), 32'(a0 + 10));
    cycles(40);
    chk("b2b_nload", 32'(ld0_t.size()), 32'd4);
    if (ld0_t.size() == 4) begin
      chk("b2b_lat", 32'(ld0_t[0]), 32'(a0 + 1));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b2b_t%0d", i), 32'(ld0_t[i] - ld0_t[0]), 32'(8 * i));
        chk($sformatf("b2b_v%0d", i), 32'(ld0_v[i]), 32'(vals[i]));
        chk($sformatf("b2b_ser%0d", i), 32'(word0(a0 + 2 + 8 * i)), 32'(vals[i]));
      end
    end

    // Push exactly on the slot-end edge while one word is buffered
    ld0_t.delete(); ld0_v.delete();
    push0(8'h11, b0);
    push0(8'h22, b1);
    wait_until(b0 + 8);
    push0(8'h33, b2);
    chk("same_edge_acc", 32'(b2), 32'(b0 + 9));
    cycles(30);
    chk("same_edge_nload", 32'(ld0_t.size()), 32'd3);
    if (ld0_t.size() == 3) begin
      chk("se_t0", 32'(ld0_t[0]), 32'(b0 + 1));
      chk("se_t1", 32'(ld0_t[1]), 32'(b0 + 9));
      chk("se_t2", 32'(ld0_t[2]), 32'(b0 + 17));
      chk("se_v0", 32'(ld0_v[0]), 32'h11);
      chk("se_v1", 32'(ld0_v[1]), 32'h22);
      chk("se_v2", 32'(ld0_v[2]), 32'h33);
    end

    // GAP=3 instance
    ld3_t.delete(); ld3_v.delete();
    push3(8'hC3, g0);
    push3(8'h5A, g1);
    cycles(30);
    chk("gap_nload", 32'(ld3_t.size()), 32'd2);
    if (ld3_t.size() == 2) begin
      lx = ld3_t[0];
      chk("gap_lat",    32'(lx), 32'(g0 + 1));
      chk("gap_period", 32'(ld3_t[1] - lx), 32'd11);
      chk("gap_ser0",   32'(word3(lx + 1)), 32'hC3);
      chk("gap_idle",   32'({ser3[lx + 9], ser3[lx + 10], ser3[lx + 11]}), 32'h7);
      chk("gap_ser1",   32'(word3(lx + 12)), 32'h5A);
      chk("gap_tail",   32'(ser3[lx + 20]), 32'd1);
    end

    // Reset in the middle of a word with one buffered
    ld0_t.delete(); ld0_v.delete();
    push0(8'hAA, r0);
    push0(8'hBB, r1);
    wait_until(r0 + 4);
    rst_n = 1'b0;
    cycles(1);
    chk("mid_rst_fill_en", 32'(o_fill_en0), 32'd0);
    chk("mid_rst_busy",    32'(o_busy0),    32'd0);
    chk("mid_rst_ready",   32'(o_ready0),   32'd0);
    rst_n = 1'b1;
    cycles(20);
    chk("mid_rst_nload", 32'(ld0_t.size()), 32'd1);
    chk("mid_rst_idle",  32'(o_busy0),      32'd0);
    push0(8'hCC, r0);
    cycles(3);
    chk("post_rst_nload", 32'(ld0_t.size()), 32'd2);
    if (ld0_t.size() == 2) chk("post_rst_fill", 32'(ld0_v[1]), 32'hCC);

`ifdef SHIFTLOAD_UNDERRUN_CNT_EN
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    chk("uc_reset", 32'(o_uc0), 32'd0);
    push0(8'h01, a0);
    push0(8'h02, a1);
    cycles(30);
    push0(8'h03, a2);
    cycles(15);
    chk("uc_two_breaks", 32'(o_uc0), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
